decode_unit: RTL and testbench

Consumer end of the instruction stream produced by the fetch stage. It accepts 16-bit instruction words over a valid/ready handshake and splits them into fields. It reads operands from an internal 16x16 register file and tracks RAW hazards with a per-register busy scoreboard. It then presents a registered decoded bundle to the execute stage over a second valid/ready handshake.

---
 rtl/decode_unit.sv | 169 ++++++++++++++++
 tb/tb_decode_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - instruction decode with hold register, register file, busy scoreboard and output stage
module decode_unit #(
  parameter int XLEN  = 16,
  parameter int NREGS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ins,
  input  logic            ins_valid,
  output logic            ins_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [3:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [3:0]      d_op,
  output logic [3:0]      d_rd,
  output logic [XLEN-1:0] d_a,
  output logic [XLEN-1:0] d_b,
  output logic [XLEN-1:0] d_s,
  output logic            d_we,
  output logic            d_mem_rd,
  output logic            d_mem_wr,
  output logic            d_branch,
  output logic            d_jump,
  output logic [11:0]     d_imm12,
  output logic            d_illegal,
  output logic            halted
);

  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic            hold_valid;
  logic [XLEN-1:0] hold_ins;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [XLEN-1:0] rf [NREGS];

  logic [3:0] op, rd, rs1, rs2;
  assign op  = hold_ins[15:12];
  assign rd  = hold_ins[11:8];
  assign rs1 = hold_ins[7:4];
  assign rs2 = hold_ins[3:0];

  logic [XLEN-1:0] rs1_val, rs2_val, rd_val, sext4, zext8;
  // Reads see a same-cycle writeback so an issuing op never needs a second pass.
  assign rs1_val = (rs1 == 4'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : rf[rs1];
  assign rs2_val = (rs2 == 4'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : rf[rs2];
  assign rd_val  = (rd  == 4'd0) ? '0 : (wb_en && wb_rd == rd)  ? wb_data : rf[rd];
  assign sext4   = {{(XLEN-4){hold_ins[3]}}, hold_ins[3:0]};
  assign zext8   = {{(XLEN-8){1'b0}}, hold_ins[7:0]};

  logic use_rs1, use_rs2, use_rd;
  logic we_dec, mem_rd_dec, mem_wr_dec, branch_dec, jump_dec, illegal_dec;
  logic [XLEN-1:0] b_dec;

  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    mem_rd_dec  = 1'b0;
    mem_wr_dec  = 1'b0;
    branch_dec  = 1'b0;
    jump_dec    = 1'b0;
    illegal_dec = 1'b0;
    b_dec       = rs2_val;
    if (op <= OP_XOR) begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end else begin
      case (op)
        OP_ADDI: begin use_rs1 = 1'b1; b_dec = sext4; end
        OP_LDI:  b_dec = zext8;
        OP_LD:   begin use_rs1 = 1'b1; b_dec = sext4; mem_rd_dec = 1'b1; end
        OP_ST:   begin use_rs1 = 1'b1; use_rd = 1'b1; b_dec = sext4; mem_wr_dec = 1'b1; end
        OP_BEQ:  begin use_rs1 = 1'b1; use_rd = 1'b1; b_dec = sext4; branch_dec = 1'b1; end
        OP_JMP:  jump_dec = 1'b1;
        OP_HALT: ;
        default: illegal_dec = 1'b1;
      endcase
    end
    we_dec = (op <= OP_LD) && (rd != 4'd0);
  end

  // A busy register being written back this cycle is already resolved via the bypass.
  logic hazard, issue, accept;
  assign hazard = (use_rs1 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
                  (use_rs2 && busy[rs2] && !(wb_en && wb_rd == rs2)) ||
                  (use_rd  && busy[rd]  && !(wb_en && wb_rd == rd));
  assign issue     = hold_valid && !hazard && (!d_valid || d_ready) && !halted && !flush;
  assign ins_ready = (!hold_valid || issue) && !halted && !flush && !rst;
  assign accept    = ins_valid && ins_ready;

  always_comb begin
    busy_nxt = busy;
    if (wb_en) busy_nxt[wb_rd] = 1'b0;
    if (issue && we_dec) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != 4'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_ins   <= '0;
      busy       <= '0;
      halted     <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (flush) hold_valid <= 1'b0;
      else if (accept) begin
        hold_valid <= 1'b1;
        hold_ins   <= ins;
      end else if (issue) hold_valid <= 1'b0;
      if (issue && op == OP_HALT) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_op      <= '0;
      d_rd      <= '0;
      d_a       <= '0;
      d_b       <= '0;
      d_s       <= '0;
      d_we      <= 1'b0;
      d_mem_rd  <= 1'b0;
      d_mem_wr  <= 1'b0;
      d_branch  <= 1'b0;
      d_jump    <= 1'b0;
      d_imm12   <= '0;
      d_illegal <= 1'b0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (issue) begin
      d_valid   <= 1'b1;
      d_op      <= op;
      d_rd      <= rd;
      d_a       <= rs1_val;
      d_b       <= b_dec;
      d_s       <= rd_val;
      d_we      <= we_dec;
      d_mem_rd  <= mem_rd_dec;
      d_mem_wr  <= mem_wr_dec;
      d_branch  <= branch_dec;
      d_jump    <= jump_dec;
      d_imm12   <= hold_ins[11:0];
      d_illegal <= illegal_dec;
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - directed vector bench for decode_unit
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst, ins_valid, ins_ready, flush, wb_en, d_ready;
  logic [15:0] ins, wb_data;
  logic [3:0]  wb_rd;
  logic        d_valid, d_we, d_mem_rd, d_mem_wr, d_branch, d_jump, d_illegal, halted;
  logic [3:0]  d_op, d_rd;
  logic [15:0] d_a, d_b, d_s;
  logic [11:0] d_imm12;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_unit dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_op(d_op), .d_rd(d_rd),
    .d_a(d_a), .d_b(d_b), .d_s(d_s), .d_we(d_we), .d_mem_rd(d_mem_rd),
    .d_mem_wr(d_mem_wr), .d_branch(d_branch), .d_jump(d_jump),
    .d_imm12(d_imm12), .d_illegal(d_illegal), .halted(halted)
  );

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a, b, s;
    logic        we;
    logic [4:0]  fl;
    logic        chk_b;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rval(input int i);
    return (i == 0) ? 16'h0000 : 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ins_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; d_ready = 1'b1;
    ins = '0; wb_rd = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_op", d_op, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ins_ready", ins_ready, 0);
    rst = 1'b0;
    #1 chk("post_rst_ins_ready", ins_ready, 1);
  endtask

  task automatic send(input logic [15:0] w);
    int cnt = 0;
    ins = w; ins_valid = 1'b1;
    while (!ins_ready && cnt < 40) begin @(negedge clk); cnt++; end
    chk("send_ready", ins_ready, 1);
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic wait_dv();
    int cnt = 0;
    @(negedge clk);
    while (!d_valid && cnt < 40) begin @(negedge clk); cnt++; end
    chk("d_valid_seen", d_valid, 1);
  endtask

  task automatic wb_pulse(input logic [3:0] r, input logic [15:0] v);
    wb_en = 1'b1; wb_rd = r; wb_data = v;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    vt[0]  = '{16'h0312, 16'h1111, 16'h1222, 16'h1333, 1'b1, 5'b00000, 1'b1};
    vt[1]  = '{16'h1A45, 16'h1444, 16'h1555, 16'h1AAA, 1'b1, 5'b00000, 1'b1};
    vt[2]  = '{16'h2067, 16'h1666, 16'h1777, 16'h0000, 1'b0, 5'b00000, 1'b1};
    vt[3]  = '{16'h540F, 16'h0000, 16'hFFFF, 16'h1444, 1'b1, 5'b00000, 1'b1};
    vt[4]  = '{16'h6B8E, 16'h1888, 16'h008E, 16'h1BBB, 1'b1, 5'b00000, 1'b1};
    vt[5]  = '{16'h7548, 16'h1444, 16'hFFF8, 16'h1555, 1'b1, 5'b10000, 1'b1};
    vt[6]  = '{16'h8973, 16'h1777, 16'h0003, 16'h1999, 1'b0, 5'b01000, 1'b1};
    vt[7]  = '{16'h9ACF, 16'h1CCC, 16'hFFFF, 16'h1AAA, 1'b0, 5'b00100, 1'b1};
    vt[8]  = '{16'hA123, 16'h1222, 16'h0000, 16'h1111, 1'b0, 5'b00010, 1'b0};
    vt[9]  = '{16'hB000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 5'b00001, 1'b0};
    vt[10] = '{16'hE7F1, 16'h1FFF, 16'h0000, 16'h1777, 1'b0, 5'b00001, 1'b0};
    vt[11] = '{16'h0F00, 16'h0000, 16'h0000, 16'h1FFF, 1'b1, 5'b00000, 1'b1};

    // Latency and back-to-back acceptance
    do_reset();
    ins = 16'h6105; ins_valid = 1'b1;
    @(negedge clk);
    chk("lat_no_early_valid", d_valid, 0);
    ins = 16'h6203;
    chk("b2b_ready", ins_ready, 1);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("ldi_valid", d_valid, 1);
    chk("ldi_op", d_op, 6);
    chk("ldi_rd", d_rd, 1);
    chk("ldi_b", d_b, 16'h0005);
    chk("ldi_we", d_we, 1);
    @(negedge clk);
    chk("ldi2_rd", d_rd, 2);
    chk("ldi2_b", d_b, 16'h0003);

    // RAW hazard released by writeback bypass
    do_reset();
    send(16'h6105);
    send(16'h0312);
    chk("haz_first_rd", d_rd, 1);
    repeat (2) begin
      @(negedge clk);
      chk("haz_stall_valid", d_valid, 0);
      chk("haz_stall_ready", ins_ready, 0);
    end
    wb_en = 1'b1; wb_rd = 4'd1; wb_data = 16'h0005;
    #1 chk("haz_release_ready", ins_ready, 1);
    @(negedge clk);
    wb_en = 1'b0;
    chk("haz_issue_valid", d_valid, 1);
    chk("haz_issue_rd", d_rd, 3);
    chk("haz_bypass_a", d_a, 16'h0005);

    // Output back-pressure
    do_reset();
    d_ready = 1'b0;
    ins = 16'h6105; ins_valid = 1'b1;
    @(negedge clk);
    ins = 16'h6203;
    @(negedge clk);
    ins = 16'h6307;
    chk("bp_rd", d_rd, 1);
    chk("bp_ready", ins_ready, 0);
    @(negedge clk);
    chk("bp_stable_rd", d_rd, 1);
    chk("bp_stable_b", d_b, 16'h0005);
    chk("bp_still_full", ins_ready, 0);
    ins_valid = 1'b0; d_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", d_valid, 1);
    chk("bp_second_rd", d_rd, 2);
    @(negedge clk);
    chk("bp_drained", d_valid, 0);

    // Flush with hold and output both occupied
    do_reset();
    d_ready = 1'b0;
    ins = 16'h6105; ins_valid = 1'b1;
    @(negedge clk);
    ins = 16'h6203;
    @(negedge clk);
    flush = 1'b1; ins = 16'h6307;
    #1 chk("flush_blocks_ins", ins_ready, 0);
    @(negedge clk);
    flush = 1'b0; d_ready = 1'b1;
    chk("flush_d_valid", d_valid, 0);
    #1 chk("flush_hold_empty", ins_ready, 1);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("flush_gap", d_valid, 0);
    @(negedge clk);
    chk("flush_next_valid", d_valid, 1);
    chk("flush_next_rd", d_rd, 3);
    chk("flush_next_b", d_b, 16'h0007);

    // Field decode table against a preloaded register file
    do_reset();
    for (int i = 1; i < 16; i++) wb_pulse(4'(i), rval(i));
    for (int i = 0; i < 12; i++) begin
      w = vt[i].ins;
      send(w);
      wait_dv();
      chk($sformatf("v%0d_op", i), d_op, w[15:12]);
      chk($sformatf("v%0d_rd", i), d_rd, w[11:8]);
      chk($sformatf("v%0d_a", i), d_a, vt[i].a);
      if (vt[i].chk_b) chk($sformatf("v%0d_b", i), d_b, vt[i].b);
      chk($sformatf("v%0d_s", i), d_s, vt[i].s);
      chk($sformatf("v%0d_we", i), d_we, vt[i].we);
      chk($sformatf("v%0d_flags", i), {d_mem_rd, d_mem_wr, d_branch, d_jump, d_illegal}, vt[i].fl);
      if (vt[i].fl[1]) chk($sformatf("v%0d_imm12", i), d_imm12, w[11:0]);
      if (vt[i].we) wb_pulse(w[11:8], rval(int'(w[11:8])));
    end

    // HALT stops intake until reset
    do_reset();
    send(16'hF000);
    wait_dv();
    chk("halt_op", d_op, 4'hF);
    chk("halt_flag", halted, 1);
    chk("halt_ready", ins_ready, 0);
    ins = 16'h6105; ins_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_ready_held", ins_ready, 0);
    chk("halt_no_issue", d_valid, 0);
    ins_valid = 1'b0;
    do_reset();
    chk("halt_cleared", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
